// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding and default WS2812 timing for the LED string blocks.
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} enc_state_t;

    localparam int CLK_MHZ = 200;

    // Nanosecond targets scaled to clock cycles.
    localparam int T0H_DEF = CLK_MHZ * 400 / 1000;
    localparam int T0L_DEF = CLK_MHZ * 850 / 1000;
    localparam int T1H_DEF = CLK_MHZ * 800 / 1000;
    localparam int T1L_DEF = CLK_MHZ * 450 / 1000;

    // Latch gap the controller leaves between frames (50 us).
    localparam int RST_CODE_CNT = CLK_MHZ * 50;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

endpackage

// File: rtl/ws2812_enc_if.sv
// ws2812_enc_if: bit handshake and LED line between frame controller and encoder.
interface ws2812_enc_if;

    logic bit_rdy_in;
    logic bit_data_in;
    logic err_clr_in;
    logic bit_done_out;
    logic busy_out;
    logic err_ovf_out;
    logic ws2812_dout_out;

    modport master (
        output bit_rdy_in, bit_data_in, err_clr_in,
        input  bit_done_out, busy_out, err_ovf_out, ws2812_dout_out
    );

    modport slave (
        input  bit_rdy_in, bit_data_in, err_clr_in,
        output bit_done_out, busy_out, err_ovf_out, ws2812_dout_out
    );

endinterface

// File: rtl/ws2812_enc.sv
// ws2812_enc: NRZ bit encoder for WS2812 strings with a one-entry hold register.
module ws2812_enc
    import ws2812_pkg::*;
#(
    parameter int T0H_CNT = T0H_DEF,
    parameter int T0L_CNT = T0L_DEF,
    parameter int T1H_CNT = T1H_DEF,
    parameter int T1L_CNT = T1L_DEF
) (
    input logic clk_in,
    input logic rst_in,
    ws2812_enc_if.slave bus
);

    localparam int CW = $clog2(max4(T0H_CNT, T0L_CNT, T1H_CNT, T1L_CNT));
    localparam logic [CW-1:0] T0H_M1 = CW'(T0H_CNT - 1);
    localparam logic [CW-1:0] T0L_M1 = CW'(T0L_CNT - 1);
    localparam logic [CW-1:0] T1H_M1 = CW'(T1H_CNT - 1);
    localparam logic [CW-1:0] T1L_M1 = CW'(T1L_CNT - 1);

    if (T0H_CNT < 2 || T0L_CNT < 2 || T1H_CNT < 2 || T1L_CNT < 2) begin : g_bad_cnt
        $error("ws2812_enc: every phase count must be at least 2");
    end

    enc_state_t state;
    logic [CW-1:0] cnt;
    logic cur_bit;
    logic hold_bit;
    logic hold_v;
    logic last_low;
    logic cap;
    logic ovf_set;

    assign last_low = state == LOW && cnt == '0;
    // The reload cycle frees the hold slot too late to take a new bit.
    assign cap = bus.bit_rdy_in && !hold_v && (state == HIGH || (state == LOW && cnt != '0));
    assign ovf_set = bus.bit_rdy_in && state != IDLE && hold_v;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt <= '0;
            cur_bit <= 1'b0;
            hold_bit <= 1'b0;
            hold_v <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.bit_rdy_in) begin
                    cur_bit <= bus.bit_data_in;
                    cnt <= bus.bit_data_in ? T1H_M1 : T0H_M1;
                    state <= HIGH;
                end
                HIGH: if (cnt == '0) begin
                    cnt <= cur_bit ? T1L_M1 : T0L_M1;
                    state <= LOW;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                LOW: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (hold_v) begin
                    cur_bit <= hold_bit;
                    hold_v <= 1'b0;
                    cnt <= hold_bit ? T1H_M1 : T0H_M1;
                    state <= HIGH;
                end else if (bus.bit_rdy_in) begin
                    cur_bit <= bus.bit_data_in;
                    cnt <= bus.bit_data_in ? T1H_M1 : T0H_M1;
                    state <= HIGH;
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (cap) begin
                hold_bit <= bus.bit_data_in;
                hold_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.ws2812_dout_out <= 1'b0;
            bus.bit_done_out <= 1'b0;
            bus.busy_out <= 1'b0;
            bus.err_ovf_out <= 1'b0;
        end else begin
            bus.ws2812_dout_out <= state == HIGH;
            bus.bit_done_out <= last_low;
            bus.busy_out <= state != IDLE || hold_v;
            bus.err_ovf_out <= ovf_set || (bus.err_ovf_out && !bus.err_clr_in);
        end
    end

endmodule

// File: tb/tb_ws2812_enc.sv
// tb_ws2812_enc: directed tables, controller handshake and random strobes against a
// schedule-level model of the encoder's waveform.
module tb_ws2812_enc;

    localparam int MAXC = 32768;
    localparam int H0 = 80, L0 = 170, H1 = 160, L1 = 90;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    ws2812_enc_if bus();

    ws2812_enc dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: every accepted bit is scheduled as a start edge; waveform derived from it.
    bit exp_dout[MAXC];
    bit exp_done[MAXC];
    bit exp_busy[MAXC];
    bit set_at[MAXC];
    bit clr_at[MAXC];
    int cur_end = 0;
    bit q_valid = 0;
    bit q_d = 0;

    function automatic int dur(input bit d);
        return d ? H1 + L1 : H0 + L0;
    endfunction

    function automatic void mark(input int st, input bit d);
        int h = d ? H1 : H0;
        for (int n = st + 1; n <= st + dur(d) && n < MAXC; n++) begin
            exp_busy[n] = 1'b1;
            if (n <= st + h) exp_dout[n] = 1'b1;
        end
        if (st + dur(d) < MAXC) exp_done[st + dur(d)] = 1'b1;
    endfunction

    function automatic void model_strobe(input int e, input bit d);
        if (q_valid && e > cur_end) begin
            cur_end += dur(q_d);
            q_valid = 0;
        end
        if (!q_valid && e >= cur_end) begin
            mark(e, d);
            cur_end = e + dur(d);
        end else if (!q_valid) begin
            q_valid = 1;
            q_d = d;
            mark(cur_end, d);
        end else if (e < MAXC) begin
            set_at[e] = 1'b1;
        end
    endfunction

    function automatic void model_reset(input int c);
        for (int n = c; n < MAXC && n < c + 1200; n++) begin
            exp_dout[n] = 0;
            exp_done[n] = 0;
            exp_busy[n] = 0;
            set_at[n] = 0;
        end
        cur_end = 0;
        q_valid = 0;
    endfunction

    // Cycle checker plus DUT activity observers for the stream test.
    bit m_err = 0;
    int dn_cnt = 0;
    int hi_len = 0;
    int hi_q[$];

    always @(negedge clk_in) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (rst_in) m_err = 0;
            else if (set_at[cyc]) m_err = 1;
            else if (clr_at[cyc]) m_err = 0;
            check($sformatf("cycle%0d {dout,done,busy,err}", cyc),
                  {28'd0, bus.ws2812_dout_out, bus.bit_done_out, bus.busy_out, bus.err_ovf_out},
                  {28'd0, exp_dout[cyc], exp_done[cyc], exp_busy[cyc], m_err});
            if (bus.bit_done_out === 1'b1) dn_cnt++;
            if (bus.ws2812_dout_out === 1'b1) hi_len++;
            else if (hi_len > 0) begin
                hi_q.push_back(hi_len);
                hi_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input bit d, input bit clr);
        bus.bit_rdy_in = 1'b1;
        bus.bit_data_in = d;
        bus.err_clr_in = clr;
        model_strobe(cyc + 1, d);
        if (clr) clr_at[cyc + 1] = 1'b1;
        tick();
        bus.bit_rdy_in = 1'b0;
        bus.err_clr_in = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int k = 0; k < 600 && !ok; k++) begin
            tick();
            ok = bus.bit_done_out;
        end
    endtask

    typedef struct {
        int at;
        bit rdy;
        bit data;
        bit clr;
        bit e_dout;
        bit e_done;
        bit e_busy;
        bit e_err;
    } vec_t;
    vec_t vq[$];

    task automatic run_vectors(input string tag);
        int b = cyc;
        foreach (vq[i]) begin
            while (cyc < b + vq[i].at) tick();
            check($sformatf("%s[%0d] dout", tag, i), bus.ws2812_dout_out, vq[i].e_dout);
            check($sformatf("%s[%0d] done", tag, i), bus.bit_done_out, vq[i].e_done);
            check($sformatf("%s[%0d] busy", tag, i), bus.busy_out, vq[i].e_busy);
            check($sformatf("%s[%0d] err", tag, i), bus.err_ovf_out, vq[i].e_err);
            if (vq[i].rdy) strobe(vq[i].data, vq[i].clr);
            else if (vq[i].clr) begin
                bus.err_clr_in = 1'b1;
                clr_at[cyc + 1] = 1'b1;
                tick();
                bus.err_clr_in = 1'b0;
            end
        end
        vq.delete();
    endtask

    initial begin
        bit ok;
        int s;
        int d0;
        int st_e[24];
        logic [23:0] pat;
        bus.bit_rdy_in = 1'b0;
        bus.bit_data_in = 1'b0;
        bus.err_clr_in = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst dout", bus.ws2812_dout_out, 1'b0);
        check("rst done", bus.bit_done_out, 1'b0);
        check("rst busy", bus.busy_out, 1'b0);
        check("rst err", bus.err_ovf_out, 1'b0);
        rst_in = 1'b0;
        repeat (5) tick();
        check("post-rst busy", bus.busy_out, 1'b0);

        // Single bit 1
        vq = '{'{0, 1, 1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 1, 0, 1, 0},
               '{161, 0, 0, 0, 1, 0, 1, 0}, '{162, 0, 0, 0, 0, 0, 1, 0}, '{250, 0, 0, 0, 0, 0, 1, 0},
               '{251, 0, 0, 0, 0, 1, 1, 0}, '{252, 0, 0, 0, 0, 0, 0, 0}};
        run_vectors("single");
        repeat (10) tick();

        // Controller handshake stream
        pat = 24'hA53CF0;
        hi_q.delete();
        d0 = dn_cnt;
        for (int i = 0; i < 24; i++) begin
            st_e[i] = cyc + 1;
            strobe(pat[23-i], 1'b0);
            wait_done(ok);
            check($sformatf("stream done %0d arrived", i), ok, 1'b1);
        end
        repeat (5) tick();
        check("stream done count", dn_cnt - d0, 24);
        check("stream high count", hi_q.size(), 24);
        for (int i = 1; i < 24; i++) check($sformatf("stream period %0d", i), st_e[i] - st_e[i-1], 251);
        for (int i = 0; i < 24 && i < hi_q.size(); i++)
            check($sformatf("stream high width %0d", i), hi_q[i], pat[23-i] ? H1 : H0);

        // Hold and overflow
        vq = '{'{0, 1, 0, 0, 0, 0, 0, 0}, '{10, 1, 1, 0, 1, 0, 1, 0}, '{20, 1, 1, 0, 1, 0, 1, 0},
               '{21, 0, 0, 0, 1, 0, 1, 1}, '{81, 0, 0, 0, 1, 0, 1, 1}, '{82, 0, 0, 0, 0, 0, 1, 1},
               '{251, 0, 0, 0, 0, 1, 1, 1}, '{252, 0, 0, 0, 1, 0, 1, 1}, '{300, 0, 0, 1, 1, 0, 1, 1},
               '{301, 0, 0, 0, 1, 0, 1, 0}, '{411, 0, 0, 0, 1, 0, 1, 0}, '{412, 0, 0, 0, 0, 0, 1, 0},
               '{501, 0, 0, 0, 0, 1, 1, 0}, '{502, 0, 0, 0, 0, 0, 0, 0}};
        run_vectors("hold");
        repeat (10) tick();

        // Mid-bit reset with a bit waiting in hold
        s = cyc + 1;
        strobe(1'b1, 1'b0);
        while (cyc < s + 9) tick();
        strobe(1'b0, 1'b0);
        while (cyc < s + 50) tick();
        check("pre-rst line high", bus.ws2812_dout_out, 1'b1);
        rst_in = 1'b1;
        model_reset(cyc);
        #1;
        check("rst line low at once", bus.ws2812_dout_out, 1'b0);
        repeat (3) tick();
        rst_in = 1'b0;
        repeat (400) tick();
        check("held bit discarded", bus.busy_out, 1'b0);
        s = cyc + 1;
        strobe(1'b0, 1'b0);
        wait_done(ok);
        check("after-rst bit done", ok, 1'b1);
        check("after-rst done timing", cyc, s + H0 + L0);
        repeat (10) tick();

        // Strobe on the final LOW cycle with hold empty
        s = cyc + 1;
        strobe(1'b0, 1'b0);
        while (cyc < s + 249) tick();
        strobe(1'b1, 1'b0);
        check("simul done", bus.bit_done_out, 1'b1);
        tick();
        check("simul restart line", bus.ws2812_dout_out, 1'b1);
        check("simul no error", bus.err_ovf_out, 1'b0);
        wait_done(ok);
        check("simul second done", ok, 1'b1);
        check("simul second timing", cyc, s + 500);
        repeat (10) tick();

        // Random strobes, gaps and clears
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 300)) tick();
            strobe(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        end
        repeat (600) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812_enc.md
# ws2812_enc

Serial line encoder for WS2812 LED strings, downstream of the frame controller. Accepts one data bit per `bit_rdy_in` pulse and drives the NRZ waveform on the LED data pin: a high phase of T0H/T1H cycles, then a low phase of T0L/T1L cycles. Pulses `bit_done_out` at the end of each bit so the controller can issue the next one. A one-entry hold register absorbs a bit that arrives mid-transmission; anything beyond that sets a sticky overflow flag.

## Interface
- `T0H_CNT`, default 80: high-phase length for a 0 bit, in clocks (0.40 us at 200 MHz)
- `T0L_CNT`, default 170: low-phase length for a 0 bit (0.85 us)
- `T1H_CNT`, default 160: high-phase length for a 1 bit (0.80 us)
- `T1L_CNT`, default 90: low-phase length for a 1 bit (0.45 us)
- `clk_in`  in  1  single system clock
- `rst_in`  in  1  asynchronous, active-high reset
- `bit_rdy_in`  in  1  one-cycle strobe; `bit_data_in` is valid
- `bit_data_in`  in  1  bit to transmit, sampled only when `bit_rdy_in` = 1
- `err_clr_in`  in  1  clears `err_ovf_out`
- `bit_done_out`  out  1  one-cycle pulse on the last low-phase cycle of each bit
- `busy_out`  out  1  high while in HIGH or LOW state, or while the hold register is valid
- `err_ovf_out`  out  1  sticky flag: a bit was dropped
- `ws2812_dout_out`  out  1  LED data line; idles low

## Operation
- States: IDLE, HIGH, LOW.
- **IDLE**
  - `bit_rdy_in` = 1: latch the data bit into `cur_bit`, load the counter with TxH−1, go to HIGH.
- **HIGH**
  - Counter decrements each cycle.
  - At 0: load TxL−1 (selected by `cur_bit`), go to LOW.
- **LOW**
  - Counter decrements each cycle; `bit_done_out` is asserted in the cycle the counter is 0.
  - Then: if the hold register is valid, move it into `cur_bit`, clear hold, load TxH−1 and go to HIGH (back-to-back); otherwise go to IDLE.
- **Hold register** (1 entry)
  - `bit_rdy_in` in HIGH or LOW with hold empty: capture the bit.
  - Hold full, or strobe coincides with the LOW→HIGH reload cycle and hold is full: drop the bit and set `err_ovf_out`.
  - Strobe in the same cycle as the final LOW cycle with hold empty: capture, then start immediately.
- **Error flag**
  - `err_ovf_out` stays set until `err_clr_in`.
  - Set has priority over clear when both occur in the same cycle.
- **Output**
  - `ws2812_dout_out` is registered: 1 exactly when the state is HIGH, otherwise 0.
- **Counter**
  - Width is `$clog2(max(all CNT))`.
  - All CNT parameters must be ≥ 2; enforce with an elaboration-time assertion.
- **Reset**
  - State IDLE, counter 0, hold empty.
  - All outputs 0: `ws2812_dout_out`, `bit_done_out`, `busy_out`, `err_ovf_out`.
  - Reset mid-bit truncates the waveform with no glitch high.

## Timing
- Strobe sampled at clock edge k.
- `ws2812_dout_out` is high for cycles k+1 .. k+TxH, then low for TxL cycles.
- `bit_done_out` is high in cycle k+TxH+TxL.
- Controller handshake (strobe answered one cycle after `bit_done_out`):
  - the encoder spends one IDLE cycle, so the effective low phase is TxL+1;
  - bit period is 251 clocks (1.255 us), within WS2812 tolerance.
- Back-to-back from hold: no IDLE cycle; bit period is exactly TxH+TxL.
- `busy_out` is registered and follows state/hold with 1-cycle latency.

## Structure
- Package `ws2812_pkg` holds:
  - the encoder state enum (`enc_state_t`: IDLE/HIGH/LOW);
  - default timing constants derived from a shared `CLK_MHZ` = 200;
  - the reset-code count shared with the controller.
- Single flat module; no sub-module.
- One `always_ff` for state, counter and hold; one for registered outputs.

## Test plan
- **Reset values:** assert `rst_in` for 3 cycles → all outputs 0, line low; release → remains idle with no pulses.
- **Single bit 1:** pulse `bit_rdy_in` with data 1 → line high 160 cycles, low 90, `bit_done_out` on cycle 250 after strobe, `busy_out` falls after.
- **Handshake stream:** model the controller (24 bits 0xA5_3C_F0, each strobe one cycle after `bit_done_out`) → high widths match the pattern (80/160), every period 251 cycles, 24 done pulses.
- **Hold and overflow:** strobe bit 0, then strobes at +10 (bit 1) and +20 (bit 1):
  - second bit transmits back-to-back (period 250);
  - third bit is dropped and `err_ovf_out` = 1;
  - `err_clr_in` clears it.
- **Mid-bit reset:** assert `rst_in` at cycle 50 of a high phase → line low immediately, hold cleared; next strobe after release transmits normally.
- **Simultaneous strobe on the final LOW cycle:** with hold empty, the bit is captured, the next bit starts the following cycle, and no error is flagged.
